// File: rtl/mdu_thread_arb.sv
// mdu_thread_arb: round-robin arbiter and fixed-latency sequencer for the shared multiplier and divider.
// Each unit is an independent instance of mdu_arb_unit; all outputs are registered.
module mdu_arb_unit #(
    parameter int LAT = 5
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic [3:0] req,
    input  logic [3:0] kill,
    output logic [3:0] gnt,
    output logic [3:0] done,
    output logic [3:0] wt,
    output logic       busy
);
    logic       busy_q, busy_d, ov_q, ov_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] owner_q, owner_d, rr_q, rr_d, pick;
    logic [3:0] gnt_q, gnt_d, done_q, done_d, wt_q, wt_d, elig;
    logic       expire, free, grant, owner_kill;

    always_comb begin
        expire     = busy_q && cnt_q == 6'd1;
        free       = !busy_q || expire;
        owner_kill = kill[owner_q];
        for (int t = 0; t < 4; t++)
            elig[t] = req[t] && !kill[t] && !(busy_q && owner_q == 2'(t) && !expire);
        // Descending scan so the nearest thread after rr_q is the one that sticks
        pick = rr_q;
        for (int k = 4; k >= 1; k--)
            if (elig[rr_q + 2'(k)]) pick = rr_q + 2'(k);
        grant   = free && |elig;
        gnt_d   = grant ? 4'b0001 << pick : 4'b0000;
        done_d  = (expire && ov_q && !owner_kill) ? 4'b0001 << owner_q : 4'b0000;
        busy_d  = grant || (busy_q && !expire);
        cnt_d   = grant ? 6'(LAT) : busy_q ? cnt_q - 6'd1 : cnt_q;
        owner_d = grant ? pick : owner_q;
        ov_d    = grant || (ov_q && !owner_kill);
        rr_d    = grant ? pick : rr_q;
        for (int t = 0; t < 4; t++)
            wt_d[t] = (elig[t] && !gnt_d[t]) || (busy_d && owner_d == 2'(t) && ov_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            busy_q  <= 1'b0;
            cnt_q   <= 6'd0;
            owner_q <= 2'd0;
            ov_q    <= 1'b0;
            rr_q    <= 2'd3;
            gnt_q   <= 4'b0000;
            done_q  <= 4'b0000;
            wt_q    <= 4'b0000;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ov_q    <= ov_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            wt_q    <= wt_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign wt   = wt_q;
    assign busy = busy_q;
endmodule

module mdu_thread_arb #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 34
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic [3:0] mul_req,
    input  logic [3:0] div_req,
    input  logic [3:0] kill,
    output logic [3:0] mul_gnt,
    output logic [3:0] div_gnt,
    output logic [3:0] mul_done,
    output logic [3:0] div_done,
    output logic [3:0] mul_wait,
    output logic [3:0] div_wait,
    output logic       mul_busy_e,
    output logic       div_busy_e
);
    mdu_arb_unit #(.LAT(MUL_LAT)) u_mul (
        .clk(clk), .rst_l(rst_l), .req(mul_req), .kill(kill),
        .gnt(mul_gnt), .done(mul_done), .wt(mul_wait), .busy(mul_busy_e)
    );

    mdu_arb_unit #(.LAT(DIV_LAT)) u_div (
        .clk(clk), .rst_l(rst_l), .req(div_req), .kill(kill),
        .gnt(div_gnt), .done(div_done), .wt(div_wait), .busy(div_busy_e)
    );
endmodule

// File: tb/tb_mdu_thread_arb.sv
// tb_mdu_thread_arb: directed scenarios plus random traffic checked every cycle against a timeline model.
module tb_mdu_thread_arb;
    localparam int ML = 5, DL = 34;

    logic clk = 1'b0, rst_l = 1'b0;
    logic [3:0] mul_req = '0, div_req = '0, kill = '0;
    logic [3:0] mul_gnt, div_gnt, mul_done, div_done, mul_wait, div_wait;
    logic mul_busy_e, div_busy_e;

    mdu_thread_arb #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .rst_l(rst_l), .mul_req(mul_req), .div_req(div_req), .kill(kill),
        .mul_gnt(mul_gnt), .div_gnt(div_gnt), .mul_done(mul_done), .div_done(div_done),
        .mul_wait(mul_wait), .div_wait(div_wait), .mul_busy_e(mul_busy_e), .div_busy_e(div_busy_e)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, n = 0, cyc = 0;
    // Model: each unit remembers the edge index at which its current op expires
    int until_m[2] = '{-1, -1}, owner_m[2] = '{0, 0}, last_m[2] = '{3, 3};
    bit alive_m[2] = '{0, 0}, e_busy[2] = '{0, 0};
    logic [3:0] e_gnt[2] = '{0, 0}, e_done[2] = '{0, 0}, e_wait[2] = '{0, 0};

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        n++;
        for (int u = 0; u < 2; u++) begin
            logic [3:0] rq, el;
            int lat;
            rq = (u == 0) ? mul_req : div_req;
            lat = (u == 0) ? ML : DL;
            e_gnt[u] = '0; e_done[u] = '0; e_wait[u] = '0; el = '0;
            if (!rst_l) begin
                until_m[u] = -1; alive_m[u] = 0; last_m[u] = 3; e_busy[u] = 0;
                continue;
            end
            for (int t = 0; t < 4; t++)
                el[t] = rq[t] && !kill[t] && !(owner_m[u] == t && until_m[u] > n);
            if (until_m[u] == n && alive_m[u] && !kill[owner_m[u]]) e_done[u][owner_m[u]] = 1'b1;
            if (kill[owner_m[u]]) alive_m[u] = 0;
            if (until_m[u] <= n && el != 0)
                for (int k = 1; k <= 4; k++) begin
                    int t;
                    t = (last_m[u] + k) % 4;
                    if (el[t]) begin
                        e_gnt[u][t] = 1'b1; until_m[u] = n + lat; owner_m[u] = t;
                        alive_m[u] = 1; last_m[u] = t;
                        break;
                    end
                end
            e_busy[u] = until_m[u] > n;
            for (int t = 0; t < 4; t++)
                e_wait[u][t] = (el[t] && !e_gnt[u][t]) || (e_busy[u] && owner_m[u] == t && alive_m[u]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk("mul_gnt", mul_gnt, e_gnt[0]);
        chk("div_gnt", div_gnt, e_gnt[1]);
        chk("mul_done", mul_done, e_done[0]);
        chk("div_done", div_done, e_done[1]);
        chk("mul_wait", mul_wait, e_wait[0]);
        chk("div_wait", div_wait, e_wait[1]);
        chk("mul_busy_e", {3'b0, mul_busy_e}, {3'b0, e_busy[0]});
        chk("div_busy_e", {3'b0, div_busy_e}, {3'b0, e_busy[1]});
    endtask

    task automatic do_reset();
        rst_l = 1'b0; mul_req = '0; div_req = '0; kill = '0;
        step(); step();
        rst_l = 1'b1;
    endtask

    initial begin
        logic [3:0] acc;
        int gcyc[4], gthr[4], ng, base;
        bit gap;
        do_reset();
        chk("pin_reset_outs", mul_gnt | div_gnt | mul_done | div_done | mul_wait | div_wait, 4'b0000);

        // Single multiply by thread 1
        mul_req = 4'b0010;
        step();
        chk("pin_s1_gnt", mul_gnt, 4'b0010);
        chk("pin_s1_wait", mul_wait, 4'b0010);
        mul_req = '0;
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("pin_s1_busy", {3'b0, mul_busy_e}, 4'b0001);
            chk("pin_s1_wait_hold", mul_wait, 4'b0010);
        end
        step();
        chk("pin_s1_done", mul_done, 4'b0010);
        chk("pin_s1_idle", {3'b0, mul_busy_e}, 4'b0000);
        step(); step();

        // Kill of thread 2 two cycles after its grant
        mul_req = 4'b0100;
        step();
        chk("pin_s3_gnt", mul_gnt, 4'b0100);
        mul_req = '0;
        step(); step();
        kill = 4'b0100;
        step();
        kill = '0;
        chk("pin_s3_wait_clr", mul_wait, 4'b0000);
        chk("pin_s3_busy", {3'b0, mul_busy_e}, 4'b0001);
        acc = 4'b0000;
        step(); acc |= mul_done;
        chk("pin_s3_busy_last", {3'b0, mul_busy_e}, 4'b0001);
        step(); acc |= mul_done;
        chk("pin_s3_released", {3'b0, mul_busy_e}, 4'b0000);
        chk("pin_s3_no_done", acc, 4'b0000);
        step();

        // Thread 3 takes both units at once while thread 0 also wants mul
        mul_req = 4'b1001; div_req = 4'b1000;
        step();
        chk("pin_s4_mgnt", mul_gnt, 4'b1000);
        chk("pin_s4_dgnt", div_gnt, 4'b1000);
        mul_req = 4'b0001; div_req = '0;
        for (int c = 1; c <= 4; c++) step();
        step();
        chk("pin_s4_mdone", mul_done, 4'b1000);
        chk("pin_s4_b2b_gnt", mul_gnt, 4'b0001);
        chk("pin_s4_b2b_busy", {3'b0, mul_busy_e}, 4'b0001);
        mul_req = '0;
        for (int c = 6; c < 34; c++) step();
        step();
        chk("pin_s4_ddone", div_done, 4'b1000);
        step();

        // Reset mid-divide abandons the op
        div_req = 4'b0010;
        step();
        chk("pin_s5_gnt", div_gnt, 4'b0010);
        div_req = '0;
        for (int c = 1; c <= 24; c++) step();
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        chk("pin_s5_zero", mul_gnt | div_gnt | mul_done | div_done | mul_wait | div_wait
            | {2'b0, mul_busy_e, div_busy_e}, 4'b0000);
        acc = 4'b0000;
        for (int c = 0; c < 40; c++) begin step(); acc |= div_done; end
        chk("pin_s5_no_done", acc, 4'b0000);
        div_req = 4'b0011;
        step();
        chk("pin_s5_prio0", div_gnt, 4'b0001);
        do_reset();

        // Thread 1 holds req across its done while thread 2 waits
        mul_req = 4'b0010;
        step();
        mul_req = 4'b0110;
        for (int c = 1; c <= 4; c++) step();
        step();
        chk("pin_s6_gnt", mul_gnt, 4'b0100);
        chk("pin_s6_done", mul_done, 4'b0010);
        chk("pin_s6_wait", mul_wait, 4'b0110);
        do_reset();

        // All four threads hold div_req from reset
        rst_l = 1'b0; div_req = 4'b1111;
        step();
        rst_l = 1'b1;
        base = cyc; ng = 0; gap = 0;
        for (int c = 1; c <= 103; c++) begin
            step();
            if (!div_busy_e) gap = 1;
            if (div_gnt != 0 && ng < 4) begin
                gcyc[ng] = cyc - base;
                gthr[ng] = (div_gnt == 4'b0001) ? 0 : (div_gnt == 4'b0010) ? 1 : (div_gnt == 4'b0100) ? 2 : 3;
                ng++;
            end
        end
        chk("pin_s2_count", 4'(ng), 4'd4);
        for (int k = 0; k < ng; k++) begin
            chk("pin_s2_cycle", 4'((gcyc[k] - 1) / 34), 4'(k));
            chk("pin_s2_cycle_exact", 4'((gcyc[k] - 1) % 34), 4'd0);
            chk("pin_s2_thread", 4'(gthr[k]), 4'(k));
        end
        chk("pin_s2_no_gap", {3'b0, gap}, 4'b0000);
        do_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_l = $urandom_range(0, 399) != 0;
            kill = '0;
            for (int t = 0; t < 4; t++) if ($urandom_range(0, 29) == 0) kill[t] = 1'b1;
            step();
            for (int t = 0; t < 4; t++) begin
                if (kill[t] || (e_gnt[0][t] && $urandom_range(0, 3) != 0)) mul_req[t] = 1'b0;
                else if (!mul_req[t] && $urandom_range(0, 2) == 0) mul_req[t] = 1'b1;
                if (kill[t] || (e_gnt[1][t] && $urandom_range(0, 3) != 0)) div_req[t] = 1'b0;
                else if (!div_req[t] && $urandom_range(0, 5) == 0) div_req[t] = 1'b1;
            end
        end
        kill = '0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_thread_arb.md
# mdu_thread_arb

Four-thread arbiter and sequencer for the shared, non-pipelined integer multiplier and divider in the IFU/EXU boundary. Per unit, it accepts per-thread requests, grants the unit round-robin, and holds the unit busy for a fixed latency. It then signals per-thread completion. Its registered per-thread wait masks and unit-busy flags are the mul_wait/div_wait/mul_busy_e/div_busy_e signals consumed by thread scheduling and the wait-mask monitor.

## Interface
- MUL_LAT, 5, multiplier occupancy in cycles; legal 2..63
- DIV_LAT, 34, divider occupancy in cycles; legal 2..63
- clk  input  1  core clock; all state updates on posedge
- rst_l  input  1  reset, synchronous, active-low
- mul_req  input  4  per-thread multiply request, level; held until mul_gnt or kill
- div_req  input  4  per-thread divide request, level; held until div_gnt or kill
- kill  input  4  per-thread flush pulse; cancels pending and in-flight ops of that thread on both units
- mul_gnt  output  4  one-hot, one-cycle multiplier grant
- div_gnt  output  4  one-hot, one-cycle divider grant
- mul_done  output  4  one-hot, one-cycle multiply completion
- div_done  output  4  one-hot, one-cycle divide completion
- mul_wait  output  4  thread waiting on multiplier (requesting-not-granted or outstanding)
- div_wait  output  4  thread waiting on divider
- mul_busy_e  output  1  multiplier occupied
- div_busy_e  output  1  divider occupied

## Operation
- Both units use identical, independent logic (LAT = MUL_LAT or DIV_LAT). A thread may hold both units at once.
- State per unit:
  - busy
  - 6-bit down-counter cnt
  - owner[1:0]
  - owner_valid (cleared by kill)
  - rr_last[1:0]
- All outputs are registered.
- Unit free at edge E: ~busy, or busy with cnt==1 (expires at E).
- Eligible[t] at E: req[t] & ~kill[t] & ~(busy & owner==t & cnt!=1). A requester that still holds req during its gnt cycle is not re-granted while outstanding.
- Arbitration at E, when free and any thread is eligible:
  - Pick the first eligible thread scanning rr_last+1, rr_last+2, … mod 4.
  - Set gnt[t]=1, busy=1, cnt=LAT, owner=t, owner_valid=1, rr_last=t.
- Occupancy: cnt decrements each cycle while busy. At the edge where cnt==1:
  - done[owner] is set if owner_valid; otherwise no done is issued.
  - busy clears, unless a new grant happens at the same edge; then busy stays 1 continuously.
- Kill:
  - kill[t] with owner==t clears owner_valid, which suppresses done.
  - The unit still stays busy for the full remaining count.
  - kill[t] removes t from arbitration at that edge.
- Wait masks, next value per thread: (eligible[t] & ~gnt_next[t]) | outstanding_next[t].
  - outstanding_next[t] = busy_next & owner_next==t & owner_valid_next.
  - A thread in its done cycle is not waiting, unless it is re-granted.
- Reset (rst_l=0 at an edge) applies mid-operation too and sets:
  - all gnt/done/wait = 0
  - busy = 0, cnt = 0, owner_valid = 0
  - rr_last = 3, so thread 0 has top priority first
- The in-flight op is abandoned with no done.

## Timing
- Request first sampled high at edge E with unit free → gnt high cycle C = E+1. Minimum request-to-grant latency is 1 cycle.
- busy_e high in cycles C .. C+LAT-1. done high in cycle C+LAT.
- Back-to-back: the next grant may be high in cycle C+LAT, the same cycle as the previous done. In that case busy_e has no gap.
- Requester must drop req by the edge ending cycle C+LAT-1. Otherwise it re-arbitrates with the completing thread's priority now lowest.
- Worst-case wait for a continuously requesting thread: 3 full occupancies, plus the current one.
- Simultaneous kill and grant for the same thread at one edge: kill wins, so no grant is issued.
- Kill in the done cycle has no effect on the done already issued.

## Test plan
- Reset, then thread 1 raises mul_req at edge 0 → mul_gnt=4'b0010 in cycle 1; mul_busy_e in cycles 1–5; mul_done=4'b0010 in cycle 6; mul_wait[1] in cycles 1–5.
- All four threads hold div_req from reset → div_gnt order is threads 0,1,2,3 at cycles 1, 35, 69, 103; div_busy_e never drops between those grants.
- Thread 2 is granted mul, and kill[2] pulses two cycles later → mul_done stays 0; mul_busy_e is still released 5 cycles after the grant; mul_wait[2] clears the cycle after kill.
- Threads 0 and 3 each request mul while thread 3 requests div at the same time → both units are granted to thread 3 concurrently; mul_done[3] lands at C+5 and div_done[3] at C+34.
- rst_l is driven low for one edge mid-divide (cnt=10) → all outputs are 0 the next cycle; no div_done ever appears; a fresh request afterwards is granted with thread 0 top priority.
- Thread 1 holds mul_req across its own done cycle while thread 2 also requests → thread 2 is granted in the done cycle; thread 1 waits.
